// File: rtl/alarm_controller.sv
// alarm_controller: alarm time registers, match detection and the RINGING/SNOOZE state machine.
// Define ALARM_SNOOZE_EN to build the SNOOZE state; otherwise a snooze press acts as dismiss.
module alarm_controller #(
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 60
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       hz_clock,
  input  logic [3:0] hours_in,
  input  logic [3:0] min10_in,
  input  logic [3:0] min1_in,
  input  logic       pm_in,
  input  logic       arm,
  input  logic       set_mode,
  input  logic       key_hour_n,
  input  logic       key_min_n,
  input  logic       key_snooze_n,
  input  logic       key_dismiss_n,
  output logic [3:0] alarm_hours,
  output logic [3:0] alarm_min10,
  output logic [3:0] alarm_min1,
  output logic       alarm_pm,
  output logic       ringing,
  output logic       snoozing,
  output logic       beep
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

  localparam int K_HOUR    = 0;
  localparam int K_MIN     = 1;
  localparam int K_SNOOZE  = 2;
  localparam int K_DISMISS = 3;

  localparam logic [15:0] RING_LAST = 16'(RING_TIMEOUT_SEC - 1);
`ifdef ALARM_SNOOZE_EN
  localparam logic [15:0] SNOOZE_LAST = 16'(SNOOZE_SEC - 1);
`endif

  logic [3:0] keys_n;
  assign keys_n = {key_dismiss_n, key_snooze_n, key_min_n, key_hour_n};

  // Synchronizers plus one extra stage for edge detection
  logic       hz_s1_q, hz_s1_d, hz_s2_q, hz_s2_d, hz_s3_q, hz_s3_d;
  logic       tick_q, tick_d;
  logic [3:0] key_s1_q, key_s1_d, key_s2_q, key_s2_d, key_s3_q, key_s3_d;
  logic [3:0] press_q, press_d;

  logic [3:0] hours_q, hours_d, min10_q, min10_d, min1_q, min1_d;
  logic       pm_q, pm_d;
  logic       match, match_q, match_d, trigger;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ringing_q, ringing_d, snoozing_q, snoozing_d;
  logic        leave;

  always_comb begin
    hz_s1_d  = hz_clock;
    hz_s2_d  = hz_s1_q;
    hz_s3_d  = hz_s2_q;
    tick_d   = hz_s2_q & ~hz_s3_q;
    key_s1_d = keys_n;
    key_s2_d = key_s1_q;
    key_s3_d = key_s2_q;
    press_d  = key_s3_q & ~key_s2_q;
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    hours_d = hours_q;
    pm_d    = pm_q;
    min10_d = min10_q;
    min1_d  = min1_q;
    if (set_mode) begin
      if (press_q[K_HOUR]) begin
        if (hours_q == 4'd12) begin
          hours_d = 4'd1;
        end else begin
          hours_d = hours_q + 4'd1;
          if (hours_q == 4'd11) pm_d = ~pm_q;
        end
      end
      if (press_q[K_MIN]) begin
        if (min1_q == 4'd9) begin
          min1_d  = 4'd0;
          min10_d = (min10_q == 4'd5) ? 4'd0 : min10_q + 4'd1;
        end else begin
          min1_d = min1_q + 4'd1;
        end
      end
    end
  end

  assign match   = (hours_in == hours_q) && (min10_in == min10_q) &&
                   (min1_in == min1_q) && (pm_in == pm_q);
  assign match_d = match;
  // Edge of match only, so a dismissed alarm stays quiet for the rest of the minute
  assign trigger = match & ~match_q;
  assign leave   = ~arm | set_mode | press_q[K_DISMISS];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ringing_d = (state_q == RINGING);
`ifdef ALARM_SNOOZE_EN
    snoozing_d = (state_q == SNOOZE);
`else
    snoozing_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (trigger && arm && !set_mode) begin
          state_d = RINGING;
          cnt_d   = '0;
        end
      end
      RINGING: begin
        if (leave) begin
          state_d = IDLE;
        end else if (press_q[K_SNOOZE]) begin
`ifdef ALARM_SNOOZE_EN
          state_d = SNOOZE;
          cnt_d   = '0;
`else
          state_d = IDLE;
`endif
        end else if (tick_q) begin
          if (cnt_q == RING_LAST) state_d = IDLE;
          else                    cnt_d   = cnt_q + 16'd1;
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (leave) begin
          state_d = IDLE;
        end else if (tick_q) begin
          if (cnt_q == SNOOZE_LAST) begin
            state_d = RINGING;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      // NOTE: synchronizers reset to the idle input level so reset release is not seen as an edge.
      hz_s1_q    <= 1'b0;
      hz_s2_q    <= 1'b0;
      hz_s3_q    <= 1'b0;
      tick_q     <= 1'b0;
      key_s1_q   <= '1;
      key_s2_q   <= '1;
      key_s3_q   <= '1;
      press_q    <= '0;
      hours_q    <= 4'd12;
      min10_q    <= 4'd0;
      min1_q     <= 4'd0;
      pm_q       <= 1'b0;
      match_q    <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      hz_s1_q    <= hz_s1_d;
      hz_s2_q    <= hz_s2_d;
      hz_s3_q    <= hz_s3_d;
      tick_q     <= tick_d;
      key_s1_q   <= key_s1_d;
      key_s2_q   <= key_s2_d;
      key_s3_q   <= key_s3_d;
      press_q    <= press_d;
      hours_q    <= hours_d;
      min10_q    <= min10_d;
      min1_q     <= min1_d;
      pm_q       <= pm_d;
      match_q    <= match_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ringing_q  <= ringing_d;
      snoozing_q <= snoozing_d;
    end
  end

  assign alarm_hours = hours_q;
  assign alarm_min10 = min10_q;
  assign alarm_min1  = min1_q;
  assign alarm_pm    = pm_q;
  assign ringing     = ringing_q;
  assign snoozing    = snoozing_q;
  assign beep        = ringing_q & hz_s2_q;

endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed scenarios plus random stimulus, checked every cycle
// against a behavioural model of the alarm rules (time as minutes, ticks as a countdown).
module tb_alarm_controller;

  localparam int RT = 4;
  localparam int SN = 3;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNOOZE_ON = 1'b1;
`else
  localparam bit SNOOZE_ON = 1'b0;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic       hz_clock = 1'b0;
  logic [3:0] hours_in = 4'd0, min10_in = 4'd0, min1_in = 4'd0;
  logic       pm_in = 1'b0, arm = 1'b0, set_mode = 1'b0;
  logic       key_hour_n = 1'b1, key_min_n = 1'b1, key_snooze_n = 1'b1, key_dismiss_n = 1'b1;
  logic [3:0] alarm_hours, alarm_min10, alarm_min1;
  logic       alarm_pm, ringing, snoozing, beep;

  alarm_controller #(.SNOOZE_SEC(SN), .RING_TIMEOUT_SEC(RT)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .hz_clock(hz_clock),
    .hours_in(hours_in), .min10_in(min10_in), .min1_in(min1_in), .pm_in(pm_in),
    .arm(arm), .set_mode(set_mode),
    .key_hour_n(key_hour_n), .key_min_n(key_min_n),
    .key_snooze_n(key_snooze_n), .key_dismiss_n(key_dismiss_n),
    .alarm_hours(alarm_hours), .alarm_min10(alarm_min10), .alarm_min1(alarm_min1),
    .alarm_pm(alarm_pm), .ringing(ringing), .snoozing(snoozing), .beep(beep)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;
  bit sim_done = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model
  typedef enum {M_IDLE, M_RING, M_SNZ} mstate_e;
  mstate_e m_state = M_IDLE;
  int      m_left = 0;
  int      m_hours = 12, m_min = 0;
  bit      m_pm = 0, m_match_q = 0;
  bit [3:0] h_hz = '0, h_kh = '1, h_km = '1, h_ks = '1, h_kd = '1;  // [0] = newest sample
  bit      p_hour = 0, p_min = 0, p_snz = 0, p_dis = 0, p_tick = 0;
  bit      m_ring = 0, m_snz = 0, m_hzs = 0;
  bit      model_valid = 0;

  task automatic model_step();
    bit match_now, trig, quit;
    model_valid = 1;
    if (!reset) begin
      m_state = M_IDLE; m_left = 0; m_hours = 12; m_min = 0; m_pm = 0; m_match_q = 0;
      h_hz = '0; h_kh = '1; h_km = '1; h_ks = '1; h_kd = '1;
      p_hour = 0; p_min = 0; p_snz = 0; p_dis = 0; p_tick = 0;
      m_ring = 0; m_snz = 0; m_hzs = 0;
      return;
    end
    match_now = (int'(hours_in) == m_hours) && (int'(min10_in) == m_min / 10) &&
                (int'(min1_in) == m_min % 10) && (pm_in == m_pm);
    trig = match_now && !m_match_q;
    m_match_q = match_now;
    m_ring = (m_state == M_RING);
    m_snz  = (m_state == M_SNZ);
    quit = !arm || set_mode || p_dis;
    case (m_state)
      M_IDLE: if (trig && arm && !set_mode) begin m_state = M_RING; m_left = RT; end
      M_RING: begin
        if (quit) m_state = M_IDLE;
        else if (p_snz) begin
          if (SNOOZE_ON) begin m_state = M_SNZ; m_left = SN; end
          else m_state = M_IDLE;
        end else if (p_tick) begin
          m_left--;
          if (m_left == 0) m_state = M_IDLE;
        end
      end
      default: begin
        if (quit) m_state = M_IDLE;
        else if (p_tick) begin
          m_left--;
          if (m_left == 0) begin m_state = M_RING; m_left = RT; end
        end
      end
    endcase
    if (set_mode && p_hour) begin
      if (m_hours == 12) m_hours = 1;
      else begin
        if (m_hours == 11) m_pm = !m_pm;
        m_hours++;
      end
    end
    if (set_mode && p_min) m_min = (m_min + 1) % 60;
    h_hz = {h_hz[2:0], hz_clock};
    h_kh = {h_kh[2:0], key_hour_n};
    h_km = {h_km[2:0], key_min_n};
    h_ks = {h_ks[2:0], key_snooze_n};
    h_kd = {h_kd[2:0], key_dismiss_n};
    p_tick = h_hz[2] & ~h_hz[3];
    p_hour = h_kh[3] & ~h_kh[2];
    p_min  = h_km[3] & ~h_km[2];
    p_snz  = h_ks[3] & ~h_ks[2];
    p_dis  = h_kd[3] & ~h_kd[2];
    m_hzs  = h_hz[1];
  endtask

  always @(negedge CLOCK_50) begin
    if (model_valid && !sim_done) begin
      check("alarm_hours", int'(alarm_hours), m_hours);
      check("alarm_min10", int'(alarm_min10), m_min / 10);
      check("alarm_min1",  int'(alarm_min1),  m_min % 10);
      check("alarm_pm",    int'(alarm_pm),    int'(m_pm));
      check("ringing",     int'(ringing),     int'(m_ring));
      check("snoozing",    int'(snoozing),    int'(m_snz));
      check("beep",        int'(beep),        int'(m_ring & m_hzs));
    end
  end

  // Stimulus helpers
  bit hz_auto = 0, hz_rand = 0;
  int hz_cnt = 0, hz_half = 3;

  task automatic step_cycle();
    @(posedge CLOCK_50);
    model_step();
    @(negedge CLOCK_50);
    if (hz_auto) begin
      hz_cnt++;
      if (hz_cnt >= hz_half) begin
        hz_cnt = 0;
        hz_clock = ~hz_clock;
        if (hz_rand) hz_half = int'($urandom_range(5, 1));
      end
    end
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0: key_hour_n = v;
      1: key_min_n = v;
      2: key_snooze_n = v;
      default: key_dismiss_n = v;
    endcase
  endtask

  task automatic press(input int k);
    set_key(k, 1'b0);
    repeat (6) step_cycle();
    set_key(k, 1'b1);
    repeat (6) step_cycle();
  endtask

  task automatic set_time(input int h, input int m, input bit p);
    hours_in = 4'(h);
    min10_in = 4'(m / 10);
    min1_in  = 4'(m % 10);
    pm_in    = p;
  endtask

  task automatic wait_ring(input logic want, input int max, input string name);
    int n = 0;
    while (ringing !== want && n < max) begin
      step_cycle();
      n++;
    end
    check(name, int'(ringing), int'(want));
  endtask

  task automatic ring_up(input string name);
    set_time(7, 31, 0);
    repeat (3) step_cycle();
    set_time(7, 30, 0);
    wait_ring(1'b1, 10, name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b0;
    repeat (3) step_cycle();
    reset = 1'b1;
    step_cycle();
    check("rst_hours", int'(alarm_hours), 12);
    check("rst_min10", int'(alarm_min10), 0);
    check("rst_min1", int'(alarm_min1), 0);
    check("rst_pm", int'(alarm_pm), 0);
    check("rst_ringing", int'(ringing), 0);

    // Set mode: 13 hour presses, 61 minute presses -> 01:01 PM
    set_mode = 1'b1;
    repeat (11) press(0);
    check("h11_hours", int'(alarm_hours), 11);
    check("h11_pm", int'(alarm_pm), 0);
    press(0);
    check("h12_hours", int'(alarm_hours), 12);
    check("h12_pm", int'(alarm_pm), 1);
    press(0);
    repeat (61) press(1);
    check("set_hours", int'(alarm_hours), 1);
    check("set_min10", int'(alarm_min10), 0);
    check("set_min1", int'(alarm_min1), 1);
    check("set_pm", int'(alarm_pm), 1);

    // 01:01 PM -> 07:30 AM
    repeat (18) press(0);
    repeat (29) press(1);
    set_mode = 1'b0;
    check("a730_hours", int'(alarm_hours), 7);
    check("a730_min10", int'(alarm_min10), 3);
    check("a730_min1", int'(alarm_min1), 0);
    check("a730_pm", int'(alarm_pm), 0);

    // Match latency
    arm = 1'b1;
    set_time(7, 29, 0);
    repeat (8) step_cycle();
    set_time(7, 30, 0);
    step_cycle();
    check("ring_lat1", int'(ringing), 0);
    step_cycle();
    check("ring_lat2", int'(ringing), 1);

    // Beep and auto-timeout
    hz_auto = 1; hz_half = 3; hz_cnt = 0;
    n = 0;
    while (beep !== 1'b1 && n < 12) begin step_cycle(); n++; end
    check("beep_follows_hz", int'(beep), 1);
    wait_ring(1'b0, 100, "timeout_off");
    repeat (20) step_cycle();
    check("no_retrigger", int'(ringing), 0);

`ifdef ALARM_SNOOZE_EN
    ring_up("ring_before_snooze");
    key_snooze_n = 1'b0;
    repeat (6) step_cycle();
    check("snooze_entered", int'(snoozing), 1);
    check("snooze_not_ring", int'(ringing), 0);
    key_snooze_n = 1'b1;
    wait_ring(1'b1, 60, "snooze_expire");
    key_dismiss_n = 1'b0;
    repeat (6) step_cycle();
    check("dismiss_ring", int'(ringing), 0);
    check("dismiss_snz", int'(snoozing), 0);
    key_dismiss_n = 1'b1;
    repeat (6) step_cycle();

    ring_up("ring_before_armdrop");
    key_snooze_n = 1'b0;
    repeat (6) step_cycle();
    check("snooze_again", int'(snoozing), 1);
    arm = 1'b0;
    repeat (2) step_cycle();
    check("arm_drop", int'(snoozing), 0);
    arm = 1'b1;
    key_snooze_n = 1'b1;
    repeat (6) step_cycle();
`else
    ring_up("ring_before_snooze");
    key_snooze_n = 1'b0;
    repeat (6) step_cycle();
    check("snooze_as_dismiss", int'(ringing), 0);
    check("snoozing_tied", int'(snoozing), 0);
    key_snooze_n = 1'b1;
    repeat (6) step_cycle();
`endif

    // Dismiss press and tick in the same cycle
    hz_auto = 0; hz_clock = 1'b0;
    ring_up("ring_before_dis_tick");
    hz_clock = 1'b1;
    key_dismiss_n = 1'b0;
    repeat (6) step_cycle();
    check("dismiss_tick", int'(ringing), 0);
    key_dismiss_n = 1'b1;
    hz_clock = 1'b0;
    repeat (6) step_cycle();

    // One-cycle reset while ringing
    hz_auto = 1; hz_cnt = 0;
    ring_up("ring_before_reset");
    reset = 1'b0;
    step_cycle();
    reset = 1'b1;
    check("mid_rst_ringing", int'(ringing), 0);
    check("mid_rst_snoozing", int'(snoozing), 0);
    check("mid_rst_beep", int'(beep), 0);
    check("mid_rst_hours", int'(alarm_hours), 12);
    check("mid_rst_min", int'(alarm_min10) * 10 + int'(alarm_min1), 0);
    check("mid_rst_pm", int'(alarm_pm), 0);

    // Random phase
    hz_rand = 1;
    arm = 1'b1;
    set_mode = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) begin
        if ($urandom_range(1) == 1) set_time(m_hours, m_min, m_pm);
        else set_time(int'($urandom_range(12, 1)), int'($urandom_range(59)), bit'($urandom_range(1)));
      end
      if ($urandom_range(29) == 0) key_hour_n = ~key_hour_n;
      if ($urandom_range(29) == 0) key_min_n = ~key_min_n;
      if ($urandom_range(29) == 0) key_snooze_n = ~key_snooze_n;
      if ($urandom_range(29) == 0) key_dismiss_n = ~key_dismiss_n;
      if ($urandom_range(149) == 0) arm = ~arm;
      if ($urandom_range(199) == 0) set_mode = ~set_mode;
      reset = ($urandom_range(799) != 0);
      step_cycle();
    end

    sim_done = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
